// File: rtl/imm_encoder.sv
// RV32I immediate encoder: scatters a signed immediate into I/S/B/J fields, 2-entry output FIFO.
// Optional range/alignment checking is enabled with `define IMM_ENCODER_RANGE_CHECK_EN.
//
// state   | meaning
// --------+----------------------------------
// S_EMPTY | no words buffered
// S_ONE   | head entry valid
// S_TWO   | head and second entry valid, input stalled
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_immsrc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [32:0] ent0_q, ent0_d;
  logic [32:0] ent1_q, ent1_d;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        push, pop;

  assign in_ready  = !reset && (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = ent0_q[31:0];
  assign out_err   = ent0_q[32];

  always_comb begin
    enc_instr = in_base;
    case (in_immsrc)
      2'b00: enc_instr = {in_imm[11:0], in_base[19:0]};
      2'b01: enc_instr = {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]};
      2'b10: enc_instr = {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1],
                          in_imm[11], in_base[6:0]};
      default: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_base[11:0]};
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic        fit_12, fit_13, fit_21;
  logic [15:0] err_cnt_q;

  // A value fits in N signed bits when every bit above N-1 equals the sign bit.
  assign fit_12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fit_13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign fit_21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    enc_err = 1'b0;
    case (in_immsrc)
      2'b00, 2'b01: enc_err = !fit_12;
      2'b10:        enc_err = !fit_13 || in_imm[0];
      default:      enc_err = !fit_21 || in_imm[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (push && enc_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_imm_bits;

  assign enc_err         = 1'b0;
  assign err_cnt         = '0;
  assign unused_imm_bits = ^{in_imm[31:21], in_imm[0]};
`endif

  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (state_q)
      S_EMPTY: begin
        if (push) begin
          ent0_d  = {enc_err, enc_instr};
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          ent0_d = {enc_err, enc_instr};
        end else if (push) begin
          ent1_d  = {enc_err, enc_instr};
          state_d = S_TWO;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a pop can occur
        if (pop) begin
          ent0_d  = ent1_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors queued at accept, checked by a monitor at pop.
module tb_imm_encoder;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_immsrc;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   exp_cnt = 0;

  imm_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_immsrc (in_immsrc),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pop is compared against the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h expected no word", out_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_err", {31'd0, out_err}, {31'd0, e.err});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] exp_i, input logic exp_e, output int waited);
    exp_t e;
    in_immsrc = src;
    in_imm    = imm;
    in_base   = base;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      e.instr = exp_i;
      e.err   = exp_e;
      exp_q.push_back(e);
      if (exp_e && exp_cnt < 65535) exp_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    int base_idx;
    exp_t e3;

    reset = 1'b1; in_valid = 1'b0; in_immsrc = 2'b00; in_imm = '0; in_base = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // encoding vectors
    send(2'b00, 32'hFFFF_FFFF, 32'h0000_0293, 32'hFFF0_0293, 1'b0, w);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    check("latency_instr", out_instr, 32'hFFF0_0293);
    send(2'b01, 32'd8, 32'h0061_2023, 32'h0061_2423, 1'b0, w);
    send(2'b11, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0, w);
    send(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, w);
    send(2'b10, 32'd2, 32'h0000_0063, 32'h0000_0163, 1'b0, w);
    send(2'b10, 32'd3, 32'h0000_0063, 32'h0000_0163, CHK, w);
    check("err_cnt_b_odd", {16'd0, err_cnt}, exp_cnt);
    send(2'b00, 32'd2047, 32'h0000_0293, 32'h7FF0_0293, 1'b0, w);
    send(2'b00, 32'hFFFF_F800, 32'h0000_0293, 32'h8000_0293, 1'b0, w);
    send(2'b00, 32'd2048, 32'h0000_0293, 32'h8000_0293, CHK, w);
    send(2'b10, 32'd4094, 32'h0000_0063, 32'h7E00_0FE3, 1'b0, w);
    send(2'b11, 32'h0010_0000, 32'h0000_00EF, 32'h8000_00EF, CHK, w);
    check("err_cnt_total", {16'd0, err_cnt}, exp_cnt);
    wait_drain("drain_vectors");

    // backpressure
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'h0000_0013, 32'h0010_0013, 1'b0, w);
    send(2'b00, 32'd2, 32'h0000_0013, 32'h0020_0013, 1'b0, w);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    in_immsrc = 2'b00; in_imm = 32'd3; in_base = 32'h0000_0013; in_valid = 1'b1;
    @(negedge clk);
    check("bp_third_blocked", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, 32'h0010_0013);
    @(posedge clk);
    #1;
    check("bp_hold_instr2", out_instr, 32'h0010_0013);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_pop_cycle", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    e3.instr = 32'h0030_0013;
    e3.err   = 1'b0;
    exp_q.push_back(e3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("drain_bp");

    // streaming at full rate
    base_idx = pop_cyc.size();
    wsum = 0;
    for (int i = 0; i < 10; i++) begin
      send(2'b00, 32'(i + 5), 32'h0000_0013, (32'(i + 5) << 20) | 32'h13, 1'b0, w);
      wsum += w;
    end
    wait_drain("drain_stream");
    check("stream_no_stall", wsum, 32'd0);
    check("stream_pops", pop_cyc.size() - base_idx, 32'd10);
    if (pop_cyc.size() - base_idx == 10)
      check("stream_consecutive", pop_cyc[base_idx + 9] - pop_cyc[base_idx], 32'd9);

    // reset with two words buffered
    out_ready = 1'b0;
    send(2'b10, 32'd5, 32'h0000_0063, 32'h0000_0263, CHK, w);
    send(2'b00, 32'd9, 32'h0000_0013, 32'h0090_0013, 1'b0, w);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_cnt = 0;
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_mid_in_ready2", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_release", {31'd0, in_ready}, 32'd1);
    send(2'b01, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0, w);
    wait_drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
